mux_scan: RTL

Parametrised N:1 registered multiplexer with two operating modes.
- Direct-select mode: the caller chooses the channel.
- Auto-scan mode: an internal round-robin sequencer steps through every channel, holding each for a fixed dwell.
- Successor to the team's combinational 8:1 mux: generalised in channel count and data width, with registered output, a valid flag, a scan-wrap pulse, and enable/hold behaviour.
- Sits between a bank of sampled sources and a single downstream consumer (logger or serialiser).

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_if.sv | 29 ++
 rtl/mux_scan_counter.sv | 51 +++++
 rtl/mux_scan.sv | 87 ++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the registered N:1 scan multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_if.sv
// Channel bus between the sampled-source side and the mux_scan output consumer.
interface mux_scan_if
    import mux_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1
) ();
    localparam int unsigned SW = $clog2(N);

    logic          en;
    mode_t         mode;
    logic [SW-1:0] sel;
    logic [N*W-1:0] d;
    logic [W-1:0]  y;
    logic [SW-1:0] ch;
    logic          valid;
    logic          wrap;

    modport master (
        output en, mode, sel, d,
        input  y, ch, valid, wrap
    );

    modport slave (
        input  en, mode, sel, d,
        output y, ch, valid, wrap
    );

endinterface

// File: rtl/mux_scan_counter.sv
// Round-robin scan position: channel index plus dwell count, wrapping at N-1.
module scan_counter
    import mux_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 step,
    output logic [$clog2(N)-1:0] pos,
    output logic                 last
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = $clog2(DWELL + 1);
    localparam logic [SW-1:0] LastPos = SW'(N - 1);
    localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

    logic [SW-1:0] cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;

    // restart forces the effective position to (0,0) without touching the registers
    always_comb begin
        pos     = restart ? '0 : cur_q;
        cnt_eff = restart ? '0 : cnt_q;
        last    = (pos == LastPos) && (cnt_eff == LastCnt);
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        if (step) begin
            if (cnt_eff == LastCnt) begin
                cnt_d = '0;
                cur_d = (pos == LastPos) ? '0 : pos + 1'b1;
            end else begin
                cnt_d = cnt_eff + 1'b1;
                cur_d = pos;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q <= '0;
            cnt_q <= '0;
        end else begin
            cur_q <= cur_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 multiplexer with caller-selected (direct) and round-robin (scan) modes.
module mux_scan
    import mux_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 4
) (
    input logic       clk,
    input logic       reset,
    mux_scan_if.slave bus
);
    localparam int unsigned SW = $clog2(N);
    localparam logic [SW:0] NumCh = (SW + 1)'(N);

    state_t        state_q;
    logic [W-1:0]  y_q;
    logic [SW-1:0] ch_q;
    logic          valid_q;
    logic          wrap_q;

    logic          scan_step;
    logic          restart;
    logic          last;
    logic          sel_ok;
    logic [SW-1:0] pos;
    logic [SW-1:0] idx;
    logic [W-1:0]  sample;

    assign scan_step = bus.en && (bus.mode == MODE_SCAN);
    // Any entry into scan from another state begins a fresh sweep at channel 0
    assign restart   = (state_q != ST_SCAN);

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .step    (scan_step),
        .pos     (pos),
        .last    (last)
    );

    always_comb begin
        idx    = (bus.mode == MODE_SCAN) ? pos : bus.sel;
        sel_ok = ({1'b0, bus.sel} < NumCh);
        sample = bus.d[idx*W +: W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            if (bus.en) begin
                if (bus.mode == MODE_SCAN) begin
                    state_q <= ST_SCAN;
                    y_q     <= sample;
                    ch_q    <= pos;
                    valid_q <= 1'b1;
                    wrap_q  <= last;
                end else begin
                    state_q <= ST_DIRECT;
                    // Out-of-range selects (non power-of-2 N) leave y/ch holding
                    if (sel_ok) begin
                        y_q     <= sample;
                        ch_q    <= bus.sel;
                        valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.y     = y_q;
    assign bus.ch    = ch_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule
